// File: rtl/spmmio_sdcard_spi_if.sv
// SP MMIO register bus bundle for the SD-card SPI peripheral.
//   adr : word address        cs  : access strobe     we : write enable
//   sel : byte-lane enables   d   : write data        q  : read data
// Bit 0 is the MSB of every vector; sel[3] covers data bits 24..31.
interface spmmio_sdcard_spi_if;
  logic [0:3]  adr;
  logic        cs;
  logic [0:3]  sel;
  logic        we;
  logic [0:31] d;
  logic [0:31] q;

  modport master (output adr, output cs, output sel, output we, output d, input q);
  modport slave  (input adr, input cs, input sel, input we, input d, output q);
endinterface

// File: rtl/spmmio_sdcard_spi.sv
// SD-card MMIO peripheral: SPI mode-0 byte engine with programmable SCK divider,
// software chip select, 0xFF fill bursts and card-detect/write-protect status.
//   clk, reset   : system clock, synchronous active-high reset
//   bus          : SP MMIO register port (slave side)
//   sdcard_cs    : card chip select, active low
//   sdcard_cd/wp : card detect (1 = present) / write protect, asynchronous
//   sdcard_sck   : SPI clock, idle low
//   sdcard_miso  : SPI data from card, asynchronous
//   sdcard_mosi  : SPI data to card, idle high
// Registers: 0 CTRL/STATUS, 1 DIV, 2 DATA, 3 FILL.
module spmmio_sdcard_spi #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned DIV_INIT  = 99,
  parameter int unsigned CD_SYNC   = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  spmmio_sdcard_spi_if.slave    bus,
  output logic                  sdcard_cs,
  input  logic                  sdcard_cd,
  input  logic                  sdcard_wp,
  output logic                  sdcard_sck,
  input  logic                  sdcard_miso,
  output logic                  sdcard_mosi
);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  logic [CD_SYNC-1:0]   cd_sync_q;
  logic                 cd_prev_q;
  logic [1:0]           wp_sync_q, miso_sync_q;
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] pre_q, pre_d, div_q, div_d, div_cur_q, div_cur_d, half_lim;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, fill_n;
  logic                 sel_q, sel_d, ovr_q, ovr_d, ins_q, ins_d, rem_q, rem_d;
  logic                 cd_s, miso_s, busy, cd_rise, cd_fall, phase_end;
  logic                 wr, wr_ctrl, wr_div, wr_data, wr_fill;
  logic [15:0]          div_ext;
  logic [0:31]          rdata;
  logic                 unused_bits;

  assign cd_s    = cd_sync_q[CD_SYNC-1];
  assign miso_s  = miso_sync_q[1];
  assign cd_rise = cd_s & ~cd_prev_q;
  assign cd_fall = ~cd_s & cd_prev_q;
  assign busy    = (state_q != StIdle);

  assign wr      = bus.cs & bus.we;
  assign wr_ctrl = wr & (bus.adr == 4'd0) & bus.sel[3];
  assign wr_div  = wr & (bus.adr == 4'd1);
  assign wr_data = wr & (bus.adr == 4'd2) & bus.sel[3];
  assign wr_fill = wr & (bus.adr == 4'd3) & bus.sel[3];
  assign fill_n  = CNT_WIDTH'(bus.d[16:31]);

  // Half-period floor of 3 cycles leaves room for the 2-flop miso synchronizer.
  assign half_lim  = (div_cur_q < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_cur_q;
  assign phase_end = (pre_q == half_lim);

  assign unused_bits = ^{bus.d[0:15], bus.sel[0:1]};

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    div_d     = div_q;
    div_cur_d = div_cur_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    ovr_d     = ovr_q;
    ins_d     = ins_q;
    rem_d     = rem_q;
    div_ext   = 16'(div_q);

    if (wr_div) begin
      if (bus.sel[2]) div_ext[15:8] = bus.d[16:23];
      if (bus.sel[3]) div_ext[7:0]  = bus.d[24:31];
      div_d = DIV_WIDTH'(div_ext);
    end

    unique case (state_q)
      StIdle: begin
        if (wr_data || (wr_fill && fill_n != '0)) begin
          state_d   = StLo;
          pre_d     = '0;
          bit_d     = 3'd7;
          div_cur_d = div_q;
          tx_d      = wr_data ? bus.d[24:31] : 8'hFF;
          if (wr_fill) cnt_d = fill_n;
        end
      end
      StLo: begin
        if (phase_end) begin
          pre_d   = '0;
          state_d = StHi;
        end else begin
          pre_d = pre_q + DIV_WIDTH'(1);
        end
      end
      StHi: begin
        if (phase_end) begin
          pre_d   = '0;
          rx_sh_d = {rx_sh_q[6:0], miso_s};
          tx_d    = {tx_q[6:0], 1'b1};
          if (bit_q == 3'd0) begin
            rx_d = {rx_sh_q[6:0], miso_s};
            if (cnt_q > CNT_WIDTH'(1)) begin
              // Next fill byte: picks up any DIV written during the last one.
              cnt_d     = cnt_q - CNT_WIDTH'(1);
              tx_d      = 8'hFF;
              bit_d     = 3'd7;
              div_cur_d = div_q;
              state_d   = StLo;
            end else begin
              cnt_d   = '0;
              state_d = StIdle;
            end
          end else begin
            bit_d   = bit_q - 3'd1;
            state_d = StLo;
          end
        end else begin
          pre_d = pre_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_ctrl) begin
      sel_d = bus.d[24];
      if (bus.d[26]) ovr_d = 1'b0;
      if (bus.d[28]) ins_d = 1'b0;
      if (bus.d[29]) rem_d = 1'b0;
    end

    // Set events are applied after W1C so they win a same-cycle collision.
    if ((wr_data || wr_fill) && busy) ovr_d = 1'b1;
    if (cd_rise) ins_d = 1'b1;
    if (cd_fall) begin
      rem_d   = 1'b1;
      sel_d   = 1'b0;
      state_d = StIdle;
      pre_d   = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.adr)
      4'd0: begin
        rdata[24] = sel_q;
        rdata[26] = ovr_q;
        rdata[27] = busy;
        rdata[28] = ins_q;
        rdata[29] = rem_q;
        rdata[30] = wp_sync_q[1];
        rdata[31] = cd_s;
      end
      4'd1:    rdata[16:31] = 16'(div_q);
      4'd2:    rdata[24:31] = rx_q;
      4'd3:    rdata[16:31] = 16'(cnt_q);
      default: rdata = '0;
    endcase
  end

  assign bus.q       = rdata;
  assign sdcard_cs   = ~sel_q;
  assign sdcard_sck  = (state_q == StHi);
  assign sdcard_mosi = (state_q == StIdle) ? 1'b1 : tx_q[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      cd_sync_q   <= '0;
      cd_prev_q   <= 1'b0;
      wp_sync_q   <= '0;
      miso_sync_q <= '0;
      state_q     <= StIdle;
      pre_q       <= '0;
      div_q       <= DIV_WIDTH'(DIV_INIT);
      div_cur_q   <= DIV_WIDTH'(DIV_INIT);
      bit_q       <= 3'd7;
      tx_q        <= 8'hFF;
      rx_sh_q     <= 8'hFF;
      rx_q        <= 8'hFF;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      ovr_q       <= 1'b0;
      ins_q       <= 1'b0;
      rem_q       <= 1'b0;
    end else begin
      cd_sync_q   <= {cd_sync_q[CD_SYNC-2:0], sdcard_cd};
      cd_prev_q   <= cd_s;
      wp_sync_q   <= {wp_sync_q[0], sdcard_wp};
      miso_sync_q <= {miso_sync_q[0], sdcard_miso};
      state_q     <= state_d;
      pre_q       <= pre_d;
      div_q       <= div_d;
      div_cur_q   <= div_cur_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_sh_q     <= rx_sh_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      ovr_q       <= ovr_d;
      ins_q       <= ins_d;
      rem_q       <= rem_d;
    end
  end

endmodule

// File: tb/tb_spmmio_sdcard_spi.sv
// Directed bench for spmmio_sdcard_spi: register access, byte timing, fill bursts,
// overrun, card detect/removal and reset abort.
module tb_spmmio_sdcard_spi;

  logic clk = 1'b0;
  logic reset;
  logic cd, wp, miso_drv, loopback;
  logic sdcard_cs, sdcard_sck, sdcard_mosi, sdcard_miso;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spmmio_sdcard_spi_if bus_if ();

  assign sdcard_miso = loopback ? sdcard_mosi : miso_drv;

  spmmio_sdcard_spi dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .sdcard_cs   (sdcard_cs),
    .sdcard_cd   (cd),
    .sdcard_wp   (wp),
    .sdcard_sck  (sdcard_sck),
    .sdcard_miso (sdcard_miso),
    .sdcard_mosi (sdcard_mosi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [3:0] s, input logic [31:0] v);
    @(negedge clk);
    bus_if.adr = a;
    bus_if.sel = s;
    bus_if.d   = v;
    bus_if.cs  = 1'b1;
    bus_if.we  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.cs  = 1'b0;
    bus_if.we  = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    bus_if.adr = a;
    #1;
    v = bus_if.q;
  endtask

  // Samples ncyc cycles after a start write, then one more to see busy fall.
  task automatic measure(input int ncyc, output int pulses, output int hi_cyc,
                         output int mosi_zero, output logic [31:0] bits,
                         output logic busy_last, output logic busy_after);
    logic prev_sck;
    prev_sck   = 1'b0;
    pulses     = 0;
    hi_cyc     = 0;
    mosi_zero  = 0;
    bits       = '0;
    bus_if.adr = 4'd0;
    busy_last  = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (sdcard_sck && !prev_sck) begin
        pulses++;
        bits = {bits[30:0], sdcard_mosi};
      end
      if (sdcard_sck) hi_cyc++;
      if (!sdcard_mosi) mosi_zero++;
      prev_sck  = sdcard_sck;
      busy_last = bus_if.q[27];
    end
    @(negedge clk);
    busy_after = bus_if.q[27];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, bits;
    logic        bl, ba;
    int          pulses, hi, mz, waited;

    bus_if.adr = '0; bus_if.sel = '0; bus_if.d = '0; bus_if.cs = 1'b0; bus_if.we = 1'b0;
    cd = 1'b0; wp = 1'b0; miso_drv = 1'b1; loopback = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    bus_read(4'd0, r);  check("reset_status", r & 32'hFC, 32'h0);
    bus_read(4'd1, r);  check("reset_div", r, 32'd99);
    bus_read(4'd2, r);  check("reset_rx", r, 32'hFF);
    check("reset_pins", {29'd0, sdcard_cs, sdcard_sck, sdcard_mosi}, 32'b101);
    bus_read(4'd7, r);  check("unmapped_read", r, 32'h0);

    // DIV=2, SEL=1, loopback byte 0xA5
    bus_write(4'd1, 4'b0011, 32'd2);
    bus_write(4'd0, 4'b0001, 32'h80);
    bus_read(4'd1, r);  check("div_rw", r, 32'd2);
    check("cs_active", {31'd0, sdcard_cs}, 32'd0);
    loopback = 1'b1;
    bus_write(4'd2, 4'b0001, 32'hA5);
    measure(48, pulses, hi, mz, bits, bl, ba);
    check("a5_pulses", pulses, 32'd8);
    check("a5_hi_cycles", hi, 32'd24);
    check("a5_mosi_bits", bits & 32'hFF, 32'hA5);
    check("a5_busy_at_48", {31'd0, bl}, 32'd1);
    check("a5_busy_after", {31'd0, ba}, 32'd0);
    bus_read(4'd2, r);  check("a5_rx", r, 32'hA5);

    // DIV=0 clamps to H=3; FILL=10 with miso high
    loopback = 1'b0;
    miso_drv = 1'b1;
    bus_write(4'd1, 4'b0011, 32'd0);
    bus_write(4'd3, 4'b0011, 32'd10);
    measure(480, pulses, hi, mz, bits, bl, ba);
    check("fill_pulses", pulses, 32'd80);
    check("fill_mosi_low", mz, 32'd0);
    check("fill_busy_at_480", {31'd0, bl}, 32'd1);
    check("fill_busy_after", {31'd0, ba}, 32'd0);
    bus_read(4'd2, r);  check("fill_rx", r, 32'hFF);
    bus_read(4'd3, r);  check("fill_count", r, 32'd0);

    // FILL=0 is a no-op
    bus_write(4'd3, 4'b0011, 32'd0);
    bus_read(4'd0, r);  check("fill0_idle", r & 32'h10, 32'h0);

    // Overrun: second DATA write mid-byte is dropped
    loopback = 1'b1;
    bus_write(4'd2, 4'b0001, 32'h3C);
    repeat (10) @(negedge clk);
    bus_write(4'd2, 4'b0001, 32'h00);
    bus_read(4'd0, r);  check("overrun_set", r & 32'h30, 32'h30);
    waited = 0;
    bus_if.adr = 4'd0;
    while (bus_if.q[27] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("overrun_done", {31'd0, bus_if.q[27]}, 32'd0);
    bus_read(4'd2, r);  check("overrun_rx", r, 32'h3C);
    bus_write(4'd0, 4'b0001, 32'hA0);
    bus_read(4'd0, r);  check("overrun_w1c", r & 32'hA0, 32'h80);

    // Card insert: flag appears CD_SYNC+1 cycles after the pin
    loopback = 1'b0;
    wp = 1'b1;
    @(negedge clk);
    cd = 1'b1;
    repeat (3) @(negedge clk);
    check("ins_early", {31'd0, bus_if.q[28]}, 32'd0);
    @(negedge clk);
    check("ins_set", {31'd0, bus_if.q[28]}, 32'd1);
    bus_read(4'd0, r);  check("cd_wp_status", r & 32'h03, 32'h03);

    // Removal during FILL=100 aborts the burst
    bus_write(4'd3, 4'b0011, 32'd100);
    repeat (50) @(negedge clk);
    cd = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.adr = 4'd0;
    #1;
    check("rem_pre_busy", bus_if.q & 32'h14, 32'h10);
    @(negedge clk);
    #1;
    check("rem_status", bus_if.q & 32'h9C, 32'h0C);
    check("rem_cs_pin", {31'd0, sdcard_cs}, 32'd1);
    bus_read(4'd3, r);  check("rem_fill", r, 32'd0);
    bus_write(4'd0, 4'b0001, 32'h0C);
    bus_read(4'd0, r);  check("rem_w1c", r & 32'h0C, 32'h0);

    // Reset mid-byte
    bus_write(4'd1, 4'b0011, 32'd2);
    bus_write(4'd0, 4'b0001, 32'h80);
    bus_write(4'd2, 4'b0001, 32'h55);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    bus_if.adr = 4'd0;
    #1;
    check("rst_pins", {29'd0, sdcard_cs, sdcard_sck, sdcard_mosi}, 32'b101);
    check("rst_busy", bus_if.q & 32'h90, 32'h0);
    bus_read(4'd1, r);  check("rst_div", r, 32'd99);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spmmio_sdcard_spi.md
Name: spmmio_sdcard_spi

Overview:
- Next-generation SD-card MMIO peripheral: SPI mode-0 byte engine with a programmable SCK divider.
- Includes software chip-select, a 0xFF fill-burst mode for card init/polling, and card-detect/write-protect status with W1C change events.
- Sits on the SP MMIO bus (4-bit word address, byte-lane selects, 32-bit data with bit 0 as MSB) and drives the SD socket pins directly.

Parameters:
- DIV_WIDTH, 16: width of the SCK divider register.
- DIV_INIT, 99: divider value after reset. Must give ≤400 kHz at the system clock.
- CD_SYNC, 3: number of synchronizer flops on sdcard_cd (minimum 2).
- CNT_WIDTH, 16: width of the fill-burst byte counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- adr  in  [0:3]  register word address
- cs  in  1  register access strobe
- sel  in  [0:3]  byte-lane enables (sel[3] = bits 24..31)
- we  in  1  write enable
- d  in  [0:31]  write data
- q  out  [0:31]  read data (combinational from adr)
- sdcard_cs  out  1  card chip select, active low
- sdcard_cd  in  1  card detect, 1 = present
- sdcard_wp  in  1  write protect
- sdcard_sck  out  1  SPI clock
- sdcard_miso  in  1  SPI data from card
- sdcard_mosi  out  1  SPI data to card

Behaviour:
- Reset (sync, all at once):
  - sdcard_cs=1, sdcard_sck=0, sdcard_mosi=1.
  - SEL=0, busy=0, inserted=removed=overrun=0, rx=0xFF, DIV=DIV_INIT, fill count=0.
  - Reset aborts any transfer in progress.
- Inputs: cd through CD_SYNC flops; wp and miso through 2 flops each.
  - inserted set on a synced cd 0->1 edge; removed set on a 1->0 edge.
- Reg 0 CTRL/STATUS, bits 24..31:
  - 24 SEL (RW): sdcard_cs = !SEL.
  - 26 overrun (W1C).
  - 27 busy (RO).
  - 28 inserted (W1C).
  - 29 removed (W1C).
  - 30 wp (RO, synced).
  - 31 cd (RO, synced).
  - Writes need sel[3]. If a set event and a W1C land in the same cycle, the set wins.
- Reg 1 DIV, bits 16..31 (low DIV_WIDTH bits):
  - RW with sel[2] covering bits 16..23 and sel[3] covering bits 24..31.
  - Half-period H = max(DIV,2)+1 clk cycles; the clamp covers miso sync latency.
  - A DIV write takes effect at the start of the next byte.
- Reg 2 DATA, bits 24..31:
  - Write with sel[3] while idle loads the TX shift register and starts one byte.
  - Write while busy is ignored and sets overrun.
  - Read returns the last received byte.
- Reg 3 FILL, bits 16..31:
  - Write with sel[3] while idle and value N>0 starts N back-to-back bytes of 0xFF.
  - Each byte's received value updates rx. Busy stays 1 until all N bytes are done.
  - N=0 is a no-op. Write while busy is ignored and sets overrun.
  - Read returns the remaining count.
- Unmapped addresses read 0; writes to them are ignored.
- FSM states IDLE, LO, HI; a prescaler counts H cycles per phase.
  - IDLE: sck=0, mosi=1. On start -> LO, busy=1 from the cycle after the write, bit index 7.
  - LO: mosi = current TX bit (MSB first), sck=0. After H cycles -> HI.
  - HI: sck=1. On the last cycle of HI, shift the synced miso into RX.
    - If bit index is 0 -> byte done; otherwise decrement the index and go to LO.
  - Byte done: rx <= shifted byte.
    - If fill remaining >1: decrement, reload 0xFF, go to LO.
    - Otherwise decrement to 0, go to IDLE, busy=0.
  - One byte lasts 16*H cycles from the write to busy falling.
- Card removal (synced cd 1->0):
  - Forces SEL=0 and aborts any transfer: go to IDLE, fill count=0, rx unchanged.
  - Sets removed.
- SEL writes during a transfer take effect immediately; software must not do this, and no protection is provided.

Test Plan:
- Reset, then read reg0/reg1 -> reg0 bits 24..29 = 0; reg1 = 99; sdcard_cs=1, sdcard_sck=0, sdcard_mosi=1.
- DIV=2, SEL=1, write DATA 0xA5 with miso looping back from mosi:
  - 8 SCK pulses of 3 high / 3 low cycles; mosi pattern 1,0,1,0,0,1,0,1.
  - busy drops 48 cycles after the write; DATA reads 0xA5.
- DIV=0 (clamped), FILL=10 with miso tied 1:
  - 80 SCK pulses with mosi held 1; busy drops after 480 cycles; DATA=0xFF; FILL reads 0.
- Write DATA again mid-byte -> overrun=1 and the transfer is unaffected. Write reg0 bit26=1 -> overrun=0.
- Drive cd 0->1, then 1->0 during a FILL=100:
  - inserted=1 after CD_SYNC+1 cycles.
  - On removal: removed=1, SEL=0, sdcard_cs=1, busy=0, FILL=0.
  - W1C of bits 28/29 clears both.
- Assert reset mid-byte -> the next cycle shows the idle pin state and busy=0; DIV returns to 99.
